// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_uart_pkg
// Brief   : Shared types and default sizing for the FIFO-fed UART transmitter.
// Revision: 1.0 - initial release
// ============================================================================
package fifo_uart_pkg;

    // Default frame geometry.
    localparam int DEFAULT_DATA_W       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    // Transmitter sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

endpackage : fifo_uart_pkg
`default_nettype wire

// File: rtl/baud_tick.sv
`default_nettype none
// ============================================================================
// Module  : baud_tick
// Brief   : Bit-period counter. It issues a one-cycle tick on the last clk of
//           every bit period and a pre-tick one cycle earlier.
// Revision: 1.0 - initial release
// ============================================================================
module baud_tick
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick,
    output logic pre_tick
);

    localparam int                 c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_PRE   = c_CNT_W'(CLKS_PER_BIT - 2);

    logic [c_CNT_W-1:0] r_cnt;

    // Count clks within a bit period. The count is held at zero while the
    // transmitter is idle or fetching, so each frame starts on a fresh period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick     = !clr && (r_cnt == c_LAST);
    assign pre_tick = !clr && (r_cnt == c_PRE);

endmodule : baud_tick
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : fifo_uart_tx
// Brief   : UART transmitter that drains a FIFO. Each word is sent as a
//           frame of 1 start bit, DATA_W data bits (LSB first) and 1 stop bit.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_r_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int                 c_IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_W - 1);

    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_tx;
    logic                r_frame_done;

    logic                w_baud_clr;
    logic                w_tick;
    logic                w_pre_tick;
    logic [DATA_W-1:0]   w_shift_nxt;

    // Bit timing stays parked while no frame is on the line.
    assign w_baud_clr  = (r_state == ST_IDLE) || (r_state == ST_FETCH);
    assign w_shift_nxt = r_shift >> 1;

    baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_baud_clr),
        .tick     (w_tick),
        .pre_tick (w_pre_tick)
    );

    // Frame sequencer: fetch a word, then shift start, data and stop bits out
    // through a registered line driver. Reset drops the frame and parks tx high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_idx        <= '0;
            r_tx         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (!fifo_empty) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Read data is valid now, one cycle after the strobe.
                    r_shift <= fifo_dout;
                    r_idx   <= '0;
                    r_tx    <= 1'b0;
                    r_state <= ST_START;
                end
                ST_START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_idx == c_IDX_LAST) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= w_shift_nxt;
                            r_tx    <= w_shift_nxt[0];
                        end
                    end
                end
                ST_STOP: begin
                    // Raised one cycle early so the pulse lands on the last stop clk.
                    if (w_pre_tick) begin
                        r_frame_done <= 1'b1;
                    end
                    if (w_tick) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The read strobe must be seen by the FIFO in the same cycle the idle
    // sequencer decides to fetch, so it is decoded rather than registered.
    assign fifo_r_en  = rst_n && (r_state == ST_IDLE) && !fifo_empty;
    assign tx         = r_tx;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;

endmodule : fifo_uart_tx
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_uart_tx
// Brief   : Directed self-checking bench for fifo_uart_tx (DATA_W=8,
//           CLKS_PER_BIT=4) driven from a small behavioural sync FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int c_DATA_W = 8;
    localparam int c_CPB    = 4;
    localparam int c_FRAME  = (c_DATA_W + 2) * c_CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fifo_empty;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_r_en;
    logic       tx;
    logic       busy;
    logic       frame_done;

    // Behavioural FIFO write port and storage.
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] mem [16];
    logic [4:0] wp = 5'd0;
    logic [4:0] rp = 5'd0;

    int n_vec = 0;
    int n_err = 0;
    int ren_cnt = 0;
    int fd_cnt  = 0;

    fifo_uart_tx #(
        .DATA_W       (c_DATA_W),
        .CLKS_PER_BIT (c_CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_r_en  (fifo_r_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Sync FIFO model: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (wr_en) begin
            mem[wp[3:0]] <= wr_data;
            wp           <= wp + 5'd1;
        end
        if (fifo_r_en === 1'b1) begin
            fifo_dout <= mem[rp[3:0]];
            rp        <= rp + 5'd1;
        end
    end
    assign fifo_empty = (wp == rp);

    // Pulse counters.
    always @(posedge clk) begin
        if (fifo_r_en === 1'b1) ren_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Advance negedge by negedge until tx goes low; count the high cycles seen.
    task automatic wait_start(output int nhigh, output bit ok);
        nhigh = 0;
        ok    = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            nhigh++;
        end
    endtask

    // Sample a whole frame starting at the current (first start) cycle.
    task automatic capture(output logic [9:0] bits, output bit stable,
                           output int fd_pos, output int fd_n);
        bits   = '0;
        stable = 1'b1;
        fd_pos = -1;
        fd_n   = 0;
        for (int c = 0; c < c_FRAME; c++) begin
            if (c > 0) @(negedge clk);
            if ((c % c_CPB) == 0) bits[c / c_CPB] = tx;
            else if (tx !== bits[c / c_CPB]) stable = 1'b0;
            if (frame_done === 1'b1) begin
                fd_n++;
                fd_pos = c;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d);
        logic [9:0] bits;
        bit         stable;
        int         fd_pos;
        int         fd_n;
        capture(bits, stable, fd_pos, fd_n);
        check({tag, " bits"},    32'(bits), 32'({1'b1, d, 1'b0}));
        check({tag, " stable"},  32'(stable), 32'd1);
        check({tag, " fd_n"},    32'(fd_n), 32'd1);
        check({tag, " fd_pos"},  32'(fd_pos), 32'(c_FRAME - 1));
    endtask

    initial begin
        int         nh;
        bit         ok;
        int         ren0;
        int         fd0;
        bit         bad_ren, bad_tx, bad_busy;
        logic [7:0] exp_b [15];

        // ---- Reset with a word waiting in the FIFO ----
        rst_n = 1'b0;
        @(negedge clk);
        push(8'hA5);
        for (int i = 0; i < 3; i++) begin
            check("rst tx",   32'(tx), 32'd1);
            check("rst r_en", 32'(fifo_r_en), 32'd0);
            check("rst busy", 32'(busy), 32'd0);
            @(negedge clk);
        end

        // ---- Single word 0xA5 ----
        ren0  = ren_cnt;
        fd0   = fd_cnt;
        rst_n = 1'b1;
        #1;
        check("release r_en", 32'(fifo_r_en), 32'd1);
        wait_start(nh, ok);
        check("a5 start seen", 32'(ok), 32'd1);
        check_frame("a5", 8'hA5);
        repeat (3) @(negedge clk);
        check("a5 r_en pulses", 32'(ren_cnt - ren0), 32'd1);
        check("a5 fd pulses",   32'(fd_cnt - fd0), 32'd1);

        // ---- Empty guard ----
        bad_ren  = 1'b0;
        bad_tx   = 1'b0;
        bad_busy = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fifo_r_en !== 1'b0) bad_ren  = 1'b1;
            if (tx !== 1'b1)        bad_tx   = 1'b1;
            if (busy !== 1'b0)      bad_busy = 1'b1;
        end
        check("empty r_en", 32'(bad_ren), 32'd0);
        check("empty tx",   32'(bad_tx), 32'd0);
        check("empty busy", 32'(bad_busy), 32'd0);

        // ---- Back-to-back 0x00, 0xFF ----
        ren0 = ren_cnt;
        fd0  = fd_cnt;
        push(8'h00);
        push(8'hFF);
        wait_start(nh, ok);
        check("b2b start0", 32'(ok), 32'd1);
        check_frame("b2b 00", 8'h00);
        wait_start(nh, ok);
        check("b2b start1", 32'(ok), 32'd1);
        check("b2b gap",    32'(nh), 32'd2);
        check("b2b empty",  32'(fifo_empty), 32'd1);
        check_frame("b2b ff", 8'hFF);
        repeat (3) @(negedge clk);
        check("b2b r_en pulses", 32'(ren_cnt - ren0), 32'd2);
        check("b2b fd pulses",   32'(fd_cnt - fd0), 32'd2);

        // ---- Mid-frame reset on 0x3C ----
        push(8'h3C);
        wait_start(nh, ok);
        check("rst3c start", 32'(ok), 32'd1);
        repeat (16) @(negedge clk);
        check("rst3c tx pre",   32'(tx), 32'd1);
        check("rst3c busy pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst3c tx async",   32'(tx), 32'd1);
        check("rst3c busy async", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        ren0     = ren_cnt;
        bad_tx   = 1'b0;
        bad_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx !== 1'b1)   bad_tx   = 1'b1;
            if (busy !== 1'b0) bad_busy = 1'b1;
        end
        check("post-rst tx",   32'(bad_tx), 32'd0);
        check("post-rst busy", 32'(bad_busy), 32'd0);
        check("post-rst r_en", 32'(ren_cnt - ren0), 32'd0);
        push(8'h81);
        wait_start(nh, ok);
        check("81 start", 32'(ok), 32'd1);
        check_frame("81", 8'h81);
        repeat (3) @(negedge clk);

        // ---- Full drain of 15 random words ----
        ren0 = ren_cnt;
        for (int i = 0; i < 15; i++) exp_b[i] = 8'($urandom_range(0, 255));
        fork
            begin
                for (int i = 0; i < 15; i++) push(exp_b[i]);
            end
            begin
                logic [9:0] bits;
                bit         stable;
                int         fd_pos;
                int         fd_n;
                for (int f = 0; f < 15; f++) begin
                    wait_start(nh, ok);
                    check("drain start", 32'(ok), 32'd1);
                    capture(bits, stable, fd_pos, fd_n);
                    check("drain frame", 32'(bits), 32'({1'b1, exp_b[f], 1'b0}));
                end
            end
        join
        check("drain last fd",   32'(frame_done), 32'd1);
        check("drain busy hold", 32'(busy), 32'd1);
        @(negedge clk);
        check("drain busy fall", 32'(busy), 32'd0);
        check("drain r_en pulses", 32'(ren_cnt - ren0), 32'd15);
        check("drain empty",       32'(fifo_empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fifo_uart_tx
`default_nettype wire

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DATA_W, default 8: width of the FIFO read data and of each serial frame's data field.
REQ-002 Parameter CLKS_PER_BIT, default 16, legal range 2..65535: clk cycles per serial bit.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port fifo_empty  input  1: FIFO read-side empty flag.
REQ-006 Port fifo_dout  input  DATA_W: FIFO read data, valid the cycle after fifo_r_en.
REQ-007 Port fifo_r_en  output  1: FIFO read strobe, one-cycle pulse per word.
REQ-008 Port tx  output  1: serial line, idle high.
REQ-009 Port busy  output  1: high whenever the state is not IDLE.
REQ-010 Port frame_done  output  1: one-cycle pulse on the last cycle of each stop bit.

Function
REQ-011 The FSM SHALL have states IDLE, FETCH, START, DATA and STOP.
REQ-012 IDLE: tx=1; if fifo_empty=0, fifo_r_en SHALL be 1 for that cycle and the next state SHALL be FETCH; otherwise the FSM SHALL stay in IDLE.
REQ-013 fifo_r_en SHALL never be asserted in any state other than IDLE, and never while fifo_empty=1.
REQ-014 FETCH (one cycle): the block SHALL capture fifo_dout into the shift register, keep tx=1, and move to START.
REQ-015 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles.
REQ-016 DATA SHALL drive DATA_W bits LSB-first, each for exactly CLKS_PER_BIT cycles.
REQ-017 STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles, assert frame_done on its last cycle, then go to IDLE.
REQ-018 A full frame SHALL last (DATA_W+2)*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-019 Back-to-back words SHALL be separated by exactly 2 tx-high cycles between the stop bit and the next start bit: one IDLE cycle plus one FETCH cycle.
REQ-020 The bit counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and wrap to 0 at CLKS_PER_BIT-1.
REQ-021 The data-bit index SHALL be ceil(log2(DATA_W)) bits wide and SHALL NOT exceed DATA_W-1.
REQ-022 fifo_empty going high during START, DATA or STOP SHALL NOT affect the frame in progress.
REQ-023 fifo_dout changing outside FETCH SHALL NOT affect the shifted data.
REQ-024 tx SHALL be driven from a flop, with no combinational path from any input to tx.

Reset
REQ-025 While rst_n=0, the block SHALL hold: state=IDLE, tx=1, fifo_r_en=0, busy=0, frame_done=0, counters=0, shift register=0.
REQ-026 Reset mid-frame SHALL abort the frame immediately, with tx forced high asynchronously; the aborted word is lost.
REQ-027 After rst_n rises, the first fifo_r_en SHALL come no earlier than the first rising clk edge with fifo_empty=0.

Structure
REQ-028 Package fifo_uart_pkg SHALL hold the state enum typedef and the default values of DATA_W and CLKS_PER_BIT.
REQ-029 Sub-module baud_tick SHALL hold the CLKS_PER_BIT counter and output a one-cycle tick; it is cleared by rst_n and whenever the FSM is in IDLE or FETCH.
REQ-030 The FSM, shift register and bit index SHALL live in fifo_uart_tx.

Verification (CLKS_PER_BIT=4, DATA_W=8, paired with the team's 8-bit sync FIFO)
REQ-031 Reset check: hold rst_n=0 for 3 cycles with fifo_empty=0 -> tx=1, fifo_r_en=0, busy=0 throughout.
REQ-032 Single word: write 0xA5 to the FIFO -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); frame_done pulses once; exactly one fifo_r_en pulse.
REQ-033 Back-to-back: write 0x00 then 0xFF -> frames are separated by exactly 2 high cycles; 2 fifo_r_en pulses; 2 frame_done pulses; FIFO is empty after the second fifo_r_en.
REQ-034 Empty guard: FIFO empty for 50 cycles -> fifo_r_en is never 1, tx=1, busy=0.
REQ-035 Mid-frame reset: pull rst_n low at cycle 17 of a 0x3C frame -> tx=1 in the same cycle (asynchronous); after release with the FIFO empty the block stays IDLE; a new word 0x81 then transmits correctly.
REQ-036 Full drain: fill the FIFO with 15 $random bytes -> 15 frames whose decoded bytes match the write order; exactly 15 fifo_r_en pulses; busy falls 1 cycle after the last frame_done.
